multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Parametrised successor to the single-cycle control decoder. It sequences RV32I instructions over several cycles through a FETCH/DECODE/EXEC/MEM/WB state machine, sharing one memory port with a ready handshake. It drives the datapath enables, ALU select and write-back mux, and keeps a retired-instruction counter. It sits between the instruction register/decoder and the shared datapath of the multi-cycle core.

Parameters:
AW, 32, address width (passed to the datapath; sets no internal widths here).
DW, 32, data width (passed to the datapath).
CNT_W, 32, width of the retired-instruction counter.
MAX_WAIT, 16, maximum number of memory wait cycles before a bus error; must be ≥ 1.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  7  opcode field of the instruction register.
func3  in  3  funct3 field.
func7  in  7  funct7 field.
br_taken  in  1  branch comparator result; valid in EXEC.
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory request; held until mem_ready.
mem_we  out  1  write strobe; qualified by mem_req.
addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
ir_en  out  1  load the instruction register.
pc_en  out  1  update the PC.
pc_sel  out  1  next PC: 0 = PC+4, 1 = ALU result.
rf_en  out  1  register-file write enable.
rd_data_sel  out  2  RD_RES / RD_MEM / RD_PC / RD_NONE.
alu_sel  out  4  ALU_* operation code.
rs1_pc_sel  out  1  0 = PC, 1 = rs1.
rs2_imm_sel  out  1  1 = rs2, 0 = immediate.
bus_err  out  1  sticky error flag after a memory timeout.
state_o  out  3  current state, for debug.
instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (asynchronous, rst_n=0) puts the FSM in FETCH. It clears instret, bus_err and the wait counter. Registered outputs reset to 0, and combinational outputs decode from FETCH.
- All control outputs are Moore/Mealy combinational from the state and the current inputs. Only the state, wait counter, instret and bus_err are registered.
- FETCH: mem_req=1, addr_sel=0, mem_we=0.
  - mem_ready=1: ir_en=1, go to DECODE.
  - mem_ready=0: stay, and increment the wait counter.
- DECODE: no enables asserted; go to EXEC.
- EXEC: alu_sel, rs1_pc_sel and rs2_imm_sel use the same rules as the single-cycle decode.
  - Branch: pc_en=1, pc_sel=br_taken, instret++, go to FETCH.
  - Load/store: go to MEM.
  - R/I/U/JAL/JALR: go to WB.
  - SYSTEM or unknown opcode: pc_en=1, pc_sel=0, go to FETCH. These are not counted.
- MEM: mem_req=1, addr_sel=1, mem_we=store.
  - mem_ready=1 and load: go to WB.
  - mem_ready=1 and store: pc_en=1, pc_sel=0, instret++, go to FETCH.
- WB: rf_en=1 and rd_data_sel per type (RES for R/I/LUI/AUIPC, MEM for load, PC for JAL/JALR).
  - pc_en=1; pc_sel=1 for JAL/JALR, else 0.
  - instret++, go to FETCH.
- Wait counter: clears on each mem_ready and on every state change.
  - When it reaches MAX_WAIT with mem_ready still low: set bus_err, drop mem_req, go to HALT.
- HALT: all enables 0. It is left only by reset.
- instret wraps modulo 2^CNT_W.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-request drops mem_req asynchronously.

Optional Feature:
MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - An unknown opcode, or an R-type with an illegal func7, enters a TRAP state for one cycle.
  - TRAP drives the added output trap_o=1 and pc_en=1 with pc_sel=1 (ALU forced to pass the mtvec constant TRAP_VEC), then goes to FETCH.
- Undefined: trap_o is absent, and the instruction is skipped as a NOP as described above.

Decomposition:
- Package multicycle_pkg:
  - state_e enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
  - Opcode constants.
  - ALU_* and RD_* codes, moved from define.svh.
- Sub-module alu_op_decode: combinational mapping of opcode/func3/func7 to alu_sel plus an illegal flag. It is shared with the single-cycle core.

Test Plan:
- ADDI with mem_ready always 1 → FETCH, DECODE, EXEC, WB, FETCH in 4 cycles; rf_en=1 only in WB; instret 0→1.
- LW with mem_ready low for 3 cycles in MEM → mem_req held 4 cycles with addr_sel=1; WB rd_data_sel=RD_MEM; 5+3 cycles total.
- BEQ with br_taken=1, then br_taken=0 → EXEC pc_en=1 with pc_sel=1, then pc_sel=0; no rf_en either time.
- SW → MEM mem_we=1; returns to FETCH without WB; rf_en never asserted.
- MAX_WAIT=4, mem_ready stuck at 0 in FETCH → after 4 cycles bus_err=1, state HALT, mem_req=0; rst_n pulse clears it.
- Opcode 7'h7F → skipped and instret unchanged; with MULTICYCLE_CTRL_TRAP_EN, trap_o pulses 1 cycle.

Source files
------------

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and codes for the multi-cycle RV32I controller
// Purpose: FSM state encoding, RV32I opcode constants, ALU and write-back
//          select codes, trap vector and the funct3-to-ALU helper.
// Ports:   none (package).
package multicycle_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] RD_RES  = 2'd0;
  localparam logic [1:0] RD_MEM  = 2'd1;
  localparam logic [1:0] RD_PC   = 2'd2;
  localparam logic [1:0] RD_NONE = 2'd3;

  // mtvec constant the datapath presents on ALU operand B while in TRAP.
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  // alt selects SUB/SRA (funct7 bit 5).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - opcode/funct to ALU operation and operand selects
// Purpose: combinational ALU decode shared by the single- and multi-cycle cores.
// Ports:   opcode[6:0], func3[2:0], func7[6:0] in;
//          alu_sel[3:0], rs1_pc_sel (0 = PC, 1 = rs1),
//          rs2_imm_sel (1 = rs2, 0 = imm), illegal (R-type bad funct7) out.
module alu_op_decode
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [3:0] alu_sel,
  output logic       rs1_pc_sel,
  output logic       rs2_imm_sel,
  output logic       illegal
);

  always_comb begin
    alu_sel     = ALU_ADD;
    rs1_pc_sel  = 1'b1;
    rs2_imm_sel = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        rs2_imm_sel = 1'b1;
        alu_sel     = alu_from_f3(func3, func7[5]);
        // Only funct7 = 0, or 0x20 on SUB/SRA, is a legal base R-type.
        illegal     = !((func7 == 7'h00) ||
                        ((func7 == 7'h20) && ((func3 == 3'b000) || (func3 == 3'b101))));
      end
      // ADDI has no SUB form; only SRAI uses funct7 bit 5.
      OPC_OP_IMM: alu_sel = alu_from_f3(func3, (func3 == 3'b101) && func7[5]);
      OPC_LUI:    alu_sel = ALU_PASS_B;
      OPC_AUIPC, OPC_JAL, OPC_BRANCH: rs1_pc_sel = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with shared memory port
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and
//          selects, times out stalled memory requests, counts retired instructions.
//          Optional macro MULTICYCLE_CTRL_TRAP_EN adds a TRAP state and trap_o.
// Ports:   clk, rst_n (async active-low); opcode/func3/func7, br_taken,
//          mem_ready in; mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel,
//          rf_en, rd_data_sel, alu_sel, rs1_pc_sel, rs2_imm_sel, bus_err,
//          state_o, [trap_o], instret out.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             rf_en,
  output logic [1:0]       rd_data_sel,
  output logic [3:0]       alu_sel,
  output logic             rs1_pc_sel,
  output logic             rs2_imm_sel,
  output logic             bus_err,
  output logic [2:0]       state_o,
`ifdef MULTICYCLE_CTRL_TRAP_EN
  output logic             trap_o,
`endif
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              bus_err_q, bus_err_d;

  logic [3:0] dec_alu_sel;
  logic       dec_rs1_pc_sel, dec_rs2_imm_sel, dec_illegal;
  logic       mem_req_c;

  alu_op_decode u_alu_op_decode (
    .opcode      (opcode),
    .func3       (func3),
    .func7       (func7),
    .alu_sel     (dec_alu_sel),
    .rs1_pc_sel  (dec_rs1_pc_sel),
    .rs2_imm_sel (dec_rs2_imm_sel),
    .illegal     (dec_illegal)
  );

  logic is_branch, is_load, is_store, is_op, is_jump, is_wb_type, timeout;
  assign is_branch  = (opcode == OPC_BRANCH);
  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign is_op      = (opcode == OPC_OP);
  assign is_jump    = (opcode == OPC_JAL) || (opcode == OPC_JALR);
  assign is_wb_type = is_op || is_jump || (opcode == OPC_OP_IMM) ||
                      (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
  // Final allowed wait cycle with the memory still not ready.
  assign timeout    = !mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    instret_d   = instret_q;
    bus_err_d   = bus_err_q;
    mem_req_c   = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    rf_en       = 1'b0;
    rd_data_sel = RD_NONE;
    alu_sel     = ALU_ADD;
    rs1_pc_sel  = 1'b0;
    rs2_imm_sel = 1'b0;
    // The ALU keeps computing the instruction's result/address through MEM and WB.
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      alu_sel     = dec_alu_sel;
      rs1_pc_sel  = dec_rs1_pc_sel;
      rs2_imm_sel = dec_rs2_imm_sel;
    end
    case (state_q)
      FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_branch) begin
          pc_en     = 1'b1;
          pc_sel    = br_taken;
          instret_d = instret_q + CNT_W'(1);
          state_d   = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else if (is_op && dec_illegal) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          state_d = TRAP;
`else
          pc_en   = 1'b1;
          state_d = FETCH;
`endif
        end else if (is_wb_type) begin
          state_d = WB;
        end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          if (opcode == OPC_SYSTEM) begin
            pc_en   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = TRAP;
          end
`else
          // SYSTEM and unknown opcodes retire nothing; just step the PC.
          pc_en   = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      MEM: begin
        mem_req_c = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_en     = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            state_d   = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end
      end
      WB: begin
        rf_en       = 1'b1;
        rd_data_sel = is_load ? RD_MEM : (is_jump ? RD_PC : RD_RES);
        pc_en       = 1'b1;
        pc_sel      = is_jump;
        instret_d   = instret_q + CNT_W'(1);
        state_d     = FETCH;
      end
      HALT: ;
      TRAP: begin
        pc_en   = 1'b1;
        pc_sel  = 1'b1;
        alu_sel = ALU_PASS_B;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Count only consecutive not-ready cycles of one memory state.
    if (mem_ready || (state_d != state_q) || !(state_q == FETCH || state_q == MEM)) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      bus_err_q <= bus_err_d;
    end
  end

  // FETCH requests memory, so gate with rst_n to drop the request while in reset.
  assign mem_req = mem_req_c & rst_n;
  assign bus_err = bus_err_q;
  assign state_o = state_q;
  assign instret = instret_q;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  assign trap_o  = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       br_taken, mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_en, pc_en, pc_sel, rf_en;
  logic [1:0] rd_data_sel;
  logic [3:0] alu_sel;
  logic       rs1_pc_sel, rs2_imm_sel, bus_err;
  logic [2:0] state_o;
  logic [3:0] instret;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic       trap_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.AW(32), .DW(32), .CNT_W(4), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .rf_en(rf_en),
    .rd_data_sel(rd_data_sel), .alu_sel(alu_sel), .rs1_pc_sel(rs1_pc_sel),
    .rs2_imm_sel(rs2_imm_sel), .bus_err(bus_err), .state_o(state_o),
`ifdef MULTICYCLE_CTRL_TRAP_EN
    .trap_o(trap_o),
`endif
    .instret(instret)
  );

  // Advance one clock: outputs are sampled by callers at the negedge, before this.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 7'h13; func3 = 3'd0; func7 = 7'd0;
    br_taken = 1'b0; mem_ready = 1'b0;
    #12;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %0b want 0", bus_err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b1 || addr_sel !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL fetch_outputs req=%0b addr=%0b we=%0b want 1 0 0", mem_req, addr_sel, mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL async_drop_req got %0b want 0", mem_req); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    opcode = 7'h13; func3 = 3'd0; func7 = 7'd0; mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== 3'd0 || ir_en !== 1'b1 || rf_en !== 1'b0) begin
      errors++; $display("FAIL addi_fetch st=%0d ir=%0b rf=%0b want 0 1 0", state_o, ir_en, rf_en); end
    tick(); @(negedge clk);
    checks++; if (state_o !== 3'd1 || ir_en !== 1'b0 || mem_req !== 1'b0 || rf_en !== 1'b0) begin
      errors++; $display("FAIL addi_decode st=%0d ir=%0b req=%0b rf=%0b want 1 0 0 0", state_o, ir_en, mem_req, rf_en); end
    tick(); @(negedge clk);
    checks++; if (state_o !== 3'd2 || alu_sel !== 4'd0 || rs1_pc_sel !== 1'b1 || rs2_imm_sel !== 1'b0 || rf_en !== 1'b0) begin
      errors++; $display("FAIL addi_exec st=%0d alu=%0d rs1=%0b rs2=%0b rf=%0b want 2 0 1 0 0", state_o, alu_sel, rs1_pc_sel, rs2_imm_sel, rf_en); end
    tick(); @(negedge clk);
    checks++; if (state_o !== 3'd4 || rf_en !== 1'b1 || rd_data_sel !== 2'd0 || pc_en !== 1'b1 || pc_sel !== 1'b0 || instret !== 4'd0) begin
      errors++; $display("FAIL addi_wb st=%0d rf=%0b rd=%0d pc_en=%0b pc_sel=%0b cnt=%0d want 4 1 0 1 0 0", state_o, rf_en, rd_data_sel, pc_en, pc_sel, instret); end
    tick();
    checks++; if (state_o !== 3'd0 || instret !== 4'd1) begin
      errors++; $display("FAIL addi_retire st=%0d cnt=%0d want 0 1", state_o, instret); end
  endtask

  task automatic test_lw_wait();
    int cycles = 0;
    int req_cycles = 0;
    opcode = 7'h03; func3 = 3'd2; func7 = 7'd0; mem_ready = 1'b1;
    repeat (2) begin @(negedge clk); cycles++; tick(); end
    @(negedge clk);
    checks++; if (state_o !== 3'd2 || alu_sel !== 4'd0 || rs2_imm_sel !== 1'b0) begin
      errors++; $display("FAIL lw_exec st=%0d alu=%0d rs2=%0b want 2 0 0", state_o, alu_sel, rs2_imm_sel); end
    cycles++; tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      @(negedge clk);
      if (state_o == 3'd3 && mem_req === 1'b1 && addr_sel === 1'b1 && mem_we === 1'b0) req_cycles++;
      cycles++; tick();
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL lw_mem_req_cycles got %0d want 4", req_cycles); end
    @(negedge clk);
    checks++; if (state_o !== 3'd4 || rd_data_sel !== 2'd1 || rf_en !== 1'b1) begin
      errors++; $display("FAIL lw_wb st=%0d rd=%0d rf=%0b want 4 1 1", state_o, rd_data_sel, rf_en); end
    cycles++; tick();
    checks++; if (cycles !== 8 || state_o !== 3'd0 || instret !== 4'd2) begin
      errors++; $display("FAIL lw_total cycles=%0d st=%0d cnt=%0d want 8 0 2", cycles, state_o, instret); end
  endtask

  task automatic test_branch();
    logic any_rf = 1'b0;
    opcode = 7'h63; func3 = 3'd0; func7 = 7'd0; mem_ready = 1'b1;
    for (int b = 1; b >= 0; b--) begin
      br_taken = b[0];
      repeat (2) begin @(negedge clk); any_rf |= rf_en; tick(); end
      @(negedge clk);
      any_rf |= rf_en;
      checks++; if (state_o !== 3'd2 || pc_en !== 1'b1 || pc_sel !== b[0]) begin
        errors++; $display("FAIL branch_exec taken=%0d st=%0d pc_en=%0b pc_sel=%0b want 2 1 %0d", b, state_o, pc_en, pc_sel, b); end
      tick();
    end
    checks++; if (any_rf !== 1'b0 || state_o !== 3'd0 || instret !== 4'd4) begin
      errors++; $display("FAIL branch_retire rf=%0b st=%0d cnt=%0d want 0 0 4", any_rf, state_o, instret); end
    br_taken = 1'b0;
  endtask

  task automatic test_sw();
    logic any_rf = 1'b0;
    opcode = 7'h23; func3 = 3'd2; func7 = 7'd0; mem_ready = 1'b1;
    repeat (3) begin @(negedge clk); any_rf |= rf_en; tick(); end
    @(negedge clk);
    any_rf |= rf_en;
    checks++; if (state_o !== 3'd3 || mem_we !== 1'b1 || mem_req !== 1'b1 || addr_sel !== 1'b1 || pc_en !== 1'b1 || pc_sel !== 1'b0) begin
      errors++; $display("FAIL sw_mem st=%0d we=%0b req=%0b addr=%0b pc_en=%0b pc_sel=%0b want 3 1 1 1 1 0", state_o, mem_we, mem_req, addr_sel, pc_en, pc_sel); end
    tick();
    checks++; if (any_rf !== 1'b0 || state_o !== 3'd0 || instret !== 4'd5) begin
      errors++; $display("FAIL sw_retire rf=%0b st=%0d cnt=%0d want 0 0 5", any_rf, state_o, instret); end
  endtask

  // Runs FETCH/DECODE then checks the EXEC and optional TRAP cycle of a skipped instruction.
  task automatic test_skip(input logic [6:0] opc, input logic [6:0] f7, input logic [3:0] cnt_exp);
    opcode = opc; func3 = 3'd0; func7 = f7; mem_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    checks++; if (state_o !== 3'd2 || pc_en !== 1'b0 || trap_o !== 1'b0) begin
      errors++; $display("FAIL trap_exec opc=%h st=%0d pc_en=%0b trap=%0b want 2 0 0", opc, state_o, pc_en, trap_o); end
    tick(); @(negedge clk);
    checks++; if (state_o !== 3'd6 || trap_o !== 1'b1 || pc_en !== 1'b1 || pc_sel !== 1'b1 || alu_sel !== 4'd10) begin
      errors++; $display("FAIL trap_state opc=%h st=%0d trap=%0b pc_en=%0b pc_sel=%0b alu=%0d want 6 1 1 1 10", opc, state_o, trap_o, pc_en, pc_sel, alu_sel); end
    tick();
    checks++; if (trap_o !== 1'b0) begin errors++; $display("FAIL trap_pulse got %0b want 0", trap_o); end
`else
    checks++; if (state_o !== 3'd2 || pc_en !== 1'b1 || pc_sel !== 1'b0 || rf_en !== 1'b0) begin
      errors++; $display("FAIL skip_exec opc=%h st=%0d pc_en=%0b pc_sel=%0b rf=%0b want 2 1 0 0", opc, state_o, pc_en, pc_sel, rf_en); end
    tick();
`endif
    checks++; if (state_o !== 3'd0 || instret !== cnt_exp) begin
      errors++; $display("FAIL skip_retire opc=%h st=%0d cnt=%0d want 0 %0d", opc, state_o, instret, cnt_exp); end
  endtask

  task automatic test_rtype_jal();
    opcode = 7'h33; func3 = 3'd0; func7 = 7'h20; mem_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (alu_sel !== 4'd1 || rs2_imm_sel !== 1'b1 || rs1_pc_sel !== 1'b1) begin
      errors++; $display("FAIL sub_exec alu=%0d rs2=%0b rs1=%0b want 1 1 1", alu_sel, rs2_imm_sel, rs1_pc_sel); end
    tick(); @(negedge clk);
    checks++; if (state_o !== 3'd4 || rd_data_sel !== 2'd0) begin
      errors++; $display("FAIL sub_wb st=%0d rd=%0d want 4 0", state_o, rd_data_sel); end
    tick();
    opcode = 7'h6F;
    repeat (2) tick();
    @(negedge clk);
    checks++; if (rs1_pc_sel !== 1'b0 || alu_sel !== 4'd0) begin
      errors++; $display("FAIL jal_exec rs1=%0b alu=%0d want 0 0", rs1_pc_sel, alu_sel); end
    tick(); @(negedge clk);
    checks++; if (rd_data_sel !== 2'd2 || pc_sel !== 1'b1 || pc_en !== 1'b1 || rf_en !== 1'b1) begin
      errors++; $display("FAIL jal_wb rd=%0d pc_sel=%0b pc_en=%0b rf=%0b want 2 1 1 1", rd_data_sel, pc_sel, pc_en, rf_en); end
    tick();
    checks++; if (instret !== 4'd7) begin errors++; $display("FAIL jal_retire cnt=%0d want 7", instret); end
  endtask

  task automatic test_wrap();
    opcode = 7'h13; func3 = 3'd0; func7 = 7'd0; mem_ready = 1'b1;
    repeat (8) repeat (4) tick();
    checks++; if (instret !== 4'd15) begin errors++; $display("FAIL wrap_max cnt=%0d want 15", instret); end
    repeat (4) tick();
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL wrap_zero cnt=%0d want 0", instret); end
  endtask

  task automatic test_fetch_wait();
    opcode = 7'h13; func3 = 3'd0; func7 = 7'd0;
    mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== 3'd0 || ir_en !== 1'b1 || bus_err !== 1'b0) begin
      errors++; $display("FAIL fetch_wait3 st=%0d ir=%0b err=%0b want 0 1 0", state_o, ir_en, bus_err); end
    tick();
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL fetch_wait3_next st=%0d want 1", state_o); end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    opcode = 7'h13; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (state_o == 3'd0 && mem_req === 1'b1) req_cycles++;
      tick();
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL timeout_req_cycles got %0d want 4", req_cycles); end
    @(negedge clk);
    checks++; if (state_o !== 3'd5 || bus_err !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_halt st=%0d err=%0b req=%0b want 5 1 0", state_o, bus_err, mem_req); end
    mem_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (state_o !== 3'd5 || pc_en !== 1'b0 || ir_en !== 1'b0 || rf_en !== 1'b0) begin
      errors++; $display("FAIL halt_sticky st=%0d pc_en=%0b ir=%0b rf=%0b want 5 0 0 0", state_o, pc_en, ir_en, rf_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state_o !== 3'd0 || bus_err !== 1'b0 || instret !== 4'd0) begin
      errors++; $display("FAIL halt_reset st=%0d err=%0b cnt=%0d want 0 0 0", state_o, bus_err, instret); end
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_sw();
    test_skip(7'h7F, 7'h00, 4'd5);
    test_rtype_jal();
    test_skip(7'h33, 7'h01, 4'd7);
    test_wrap();
    test_fetch_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
